// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: owns the fetch PC, applies hazard redirects, issues flushes and imem requests
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect_valid,
  input  logic [1:0]       redirect_sel,
  input  logic [31:0]      branch_target,
  input  logic [31:0]      jalr_target,
  input  logic [31:0]      jal_target,
  input  logic             stall,
  input  logic             imem_ready,
  output logic [31:0]      PC_OUT,
  output logic             imem_req,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic [CNT_W-1:0] redirect_count,
  output logic             misaligned_fault
);
  typedef enum logic [1:0] {IDLE, FETCH, FLUSH, HALT} state_t;
  state_t state, state_n;
  logic [31:0] pc_n, target;
  logic [CNT_W-1:0] cnt_n;
  logic fi_n, fe_n, fault_n, take;
  assign take = redirect_valid && redirect_sel != 2'b11;
  assign target = redirect_sel == 2'b00 ? branch_target :
                  redirect_sel == 2'b01 ? {jalr_target[31:1], 1'b0} : jal_target;
  assign imem_req = state == FETCH;
  always_comb begin
    state_n = state;
    pc_n = PC_OUT;
    cnt_n = redirect_count;
    fault_n = misaligned_fault;
    fi_n = 1'b0;
    fe_n = 1'b0;
    case (state)
      IDLE: state_n = FETCH;
      FETCH, FLUSH: begin
        if (take) begin
          pc_n = target;
          if (|target[1:0]) begin
            fault_n = 1'b1;
            state_n = HALT;
          end else begin
            fi_n = 1'b1;
            fe_n = redirect_sel == 2'b00;
            cnt_n = &redirect_count ? redirect_count : redirect_count + CNT_W'(1);
            state_n = FLUSH;
          end
        end else if (state == FLUSH) begin
          state_n = FETCH;
        end else if (!stall && imem_ready) begin
          pc_n = PC_OUT + 32'd4;
        end
      end
      default: state_n = HALT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      PC_OUT <= RESET_PC;
      flush_IF_ID <= 1'b0;
      flush_ID_EX <= 1'b0;
      redirect_count <= '0;
      misaligned_fault <= 1'b0;
    end else begin
      state <= state_n;
      PC_OUT <= pc_n;
      flush_IF_ID <= fi_n;
      flush_ID_EX <= fe_n;
      redirect_count <= cnt_n;
      misaligned_fault <= fault_n;
    end
  end
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: randomized + directed stimulus, queue scoreboard against a cycle-level reference model
module tb_pc_redirect_unit;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic redirect_valid = 1'b0;
  logic [1:0] redirect_sel = 2'b11;
  logic [31:0] branch_target = '0, jalr_target = '0, jal_target = '0;
  logic stall = 1'b0, imem_ready = 1'b1;
  logic [31:0] PC_OUT;
  logic imem_req, flush_IF_ID, flush_ID_EX, misaligned_fault;
  logic [CW-1:0] redirect_count;
  always #5 clk = ~clk;
  pc_redirect_unit #(.RESET_PC(32'h0), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_sel(redirect_sel),
    .branch_target(branch_target), .jalr_target(jalr_target), .jal_target(jal_target),
    .stall(stall), .imem_ready(imem_ready), .PC_OUT(PC_OUT), .imem_req(imem_req),
    .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX), .redirect_count(redirect_count),
    .misaligned_fault(misaligned_fault)
  );
  typedef struct packed {
    logic [31:0] pc;
    logic req;
    logic fi;
    logic fe;
    logic [CW-1:0] cnt;
    logic fault;
  } exp_t;
  exp_t q[$];
  int vectors = 0, miscompares = 0;
  // model: mode 0 startup, 1 fetching, 2 bubble after redirect, 3 halted
  int m_mode = 0, m_cnt = 0;
  logic [31:0] m_pc = '0;
  logic m_fi = 1'b0, m_fe = 1'b0, m_fault = 1'b0;
  task automatic step(input logic r, input logic v, input logic [1:0] s, input logic [31:0] bt,
                      input logic [31:0] jt, input logic [31:0] lt, input logic st, input logic rd);
    logic [31:0] t;
    @(negedge clk);
    reset = r; redirect_valid = v; redirect_sel = s;
    branch_target = bt; jalr_target = jt; jal_target = lt; stall = st; imem_ready = rd;
    t = s == 2'd0 ? bt : s == 2'd1 ? (jt & ~32'd1) : lt;
    m_fi = 1'b0;
    m_fe = 1'b0;
    if (!r) begin
      m_mode = 0; m_pc = 32'h0; m_cnt = 0; m_fault = 1'b0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode != 3) begin
      if (v && s != 2'd3) begin
        m_pc = t;
        if (t % 4 != 0) begin
          m_fault = 1'b1;
          m_mode = 3;
        end else begin
          m_fi = 1'b1;
          m_fe = s == 2'd0;
          m_cnt = m_cnt < CMAX ? m_cnt + 1 : CMAX;
          m_mode = 2;
        end
      end else if (m_mode == 2) m_mode = 1;
      else if (!st && rd) m_pc = m_pc + 32'd4;
    end
    q.push_back(exp_t'{m_pc, m_mode == 1, m_fi, m_fe, CW'(m_cnt), m_fault});
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 2'd3, 0, 0, 0, 0, 1);
  endtask
  task automatic redir(input logic [1:0] s, input logic [31:0] t, input logic st);
    step(1, 1, s, s == 2'd0 ? t : 32'hDEAD_0010, s == 2'd1 ? t : 32'hDEAD_0020,
         s == 2'd2 ? t : 32'hDEAD_0030, st, 1);
  endtask
  initial begin
    exp_t e, got;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        got = {PC_OUT, imem_req, flush_IF_ID, flush_ID_EX, redirect_count, misaligned_fault};
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL vec%0d: got pc=%h req=%b fi=%b fe=%b cnt=%0d flt=%b, want pc=%h req=%b fi=%b fe=%b cnt=%0d flt=%b",
                   vectors, got.pc, got.req, got.fi, got.fe, got.cnt, got.fault,
                   e.pc, e.req, e.fi, e.fe, e.cnt, e.fault);
        end
      end
    end
  end
  initial begin
    logic [31:0] bt, jt, lt;
    repeat (3) step(0, 0, 2'd3, 0, 0, 0, 0, 1);
    idle(5);
    redir(2'd0, 32'h100, 0); idle(2);
    redir(2'd1, 32'h205, 0); idle(2);
    redir(2'd2, 32'h40, 0); idle(2);
    repeat (3) step(1, 0, 2'd3, 0, 0, 0, 1, 1);
    repeat (2) step(1, 0, 2'd3, 0, 0, 0, 0, 0);
    redir(2'd0, 32'h300, 1); idle(2);
    redir(2'd0, 32'h80, 0); redir(2'd2, 32'hC0, 0); idle(2);
    step(1, 1, 2'd3, 32'h500, 32'h500, 32'h500, 0, 1); idle(1);
    redir(2'd2, 32'hFFFF_FFF8, 0); idle(4);
    repeat (17) redir(2'd2, 32'h400, 0);
    idle(2);
    redir(2'd0, 32'h102, 0);
    redir(2'd2, 32'h600, 0); idle(3);
    step(0, 0, 2'd3, 0, 0, 0, 0, 1); idle(3);
    for (int i = 0; i < 3000; i++) begin
      bt = $urandom_range(0, 7) == 0 ? $urandom : ($urandom & ~32'd3);
      jt = $urandom_range(0, 7) == 0 ? $urandom : ($urandom & ~32'd2);
      lt = $urandom_range(0, 7) == 0 ? $urandom : ($urandom & ~32'd3);
      step($urandom_range(0, 99) != 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
           bt, jt, lt, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
    end
    idle(1);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
Consumer end of the control-hazard redirect interface. It takes the 2-bit redirect select and PC-mux strobe produced by the hazard decision logic, owns the architectural fetch PC, and generates the next fetch address. It also issues registered IF/ID and ID/EX flush pulses and runs the instruction-memory request handshake. It sits between the hazard logic and the IF stage / instruction memory.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset
CNT_W, 16, width of the saturating redirect counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
redirect_valid  input  1  PC-mux strobe from hazard logic; 1 = take redirect
redirect_sel  input  2  00 branch, 01 JALR, 10 JAL, 11 none
branch_target  input  32  resolved conditional-branch target
jalr_target  input  32  rs1+imm JALR target, bit0 not yet cleared
jal_target  input  32  PC-relative JAL target
stall  input  1  load-use stall; hold PC
imem_ready  input  1  instruction memory accepts the current request
PC_OUT  output  32  current fetch address
imem_req  output  1  fetch request valid
flush_IF_ID  output  1  registered one-cycle flush pulse
flush_ID_EX  output  1  registered one-cycle flush pulse, branch only
redirect_count  output  CNT_W  redirects taken, saturating
misaligned_fault  output  1  sticky target-misaligned flag

Behaviour:
- Reset: sampled on the clk edge while reset=0. Sets PC_OUT=RESET_PC, imem_req=0, both flushes=0, redirect_count=0, misaligned_fault=0, state=IDLE. Reset overrides all other inputs and is honoured in every state, including HALT.
- FSM states: IDLE, FETCH, FLUSH, HALT.
- IDLE: on the first edge with reset=1, moves to FETCH. imem_req=0 while in IDLE.
- A redirect is taken only when redirect_valid=1 and redirect_sel!=11. valid=1 with sel=11 is ignored (treated as no redirect).
- Target select: 00 -> branch_target; 01 -> {jalr_target[31:1],1'b0}; 10 -> jal_target.
- FETCH: imem_req=1. Priority is reset > redirect > stall > memory wait > advance.
  - Redirect taken: PC_OUT<=target, flush_IF_ID<=1, flush_ID_EX<=(sel==00), redirect_count++ (saturates at all-ones), state<=FLUSH.
  - Else if stall=1 or imem_ready=0: hold PC_OUT.
  - Else: PC_OUT<=PC_OUT+4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- FLUSH: exactly one bubble cycle. imem_req=0; the flush outputs registered on entry are high during this cycle. Next state is FETCH, and both flushes return to 0.
  - A new redirect arriving in FLUSH is taken: it reloads PC_OUT, re-registers the flushes per its sel, increments the counter, and stays in FLUSH one more cycle.
  - stall is ignored in FLUSH.
- Misalignment: if the selected target (after JALR bit0 clear) has bits[1:0]!=00, then PC_OUT<=target, misaligned_fault<=1 (sticky), no flush is issued, the counter is not incremented, and state<=HALT.
- HALT: imem_req=0, PC_OUT frozen, all inputs ignored. Exit is by reset only.
- Latency: redirect to new PC_OUT is 1 cycle. The first imem_req on the new PC is 2 cycles after the redirect cycle (one bubble).
- Flush outputs are never asserted outside the single FLUSH cycle.
- Reset mid-FLUSH clears the flushes on the same edge.

Test Plan:
- Reset/startup: hold reset=0 for 3 cycles, release, imem_ready=1 -> PC_OUT=0, 0, then 4, 8, 12 on successive cycles; imem_req rises one cycle after release.
- Branch redirect: at PC=0x10, valid=1, sel=00, branch_target=0x100 -> next cycle PC_OUT=0x100, flush_IF_ID=1, flush_ID_EX=1, imem_req=0, count=1; following cycle imem_req=1, flushes=0.
- JALR bit-clear and JAL: sel=01, jalr_target=0x205 -> PC_OUT=0x204, only flush_IF_ID=1. sel=10, jal_target=0x40 -> PC_OUT=0x40, only flush_IF_ID=1.
- Stall/backpressure: stall=1 for 3 cycles, then imem_ready=0 for 2 cycles -> PC_OUT constant for 5 cycles. A redirect asserted during stall is still taken.
- Back-to-back redirect in FLUSH and ignored combo: redirect to 0x80, then immediately sel=10 to 0xC0 -> PC_OUT=0xC0, FLUSH held 2 cycles, count=2. valid=1 with sel=11 -> PC advances by 4, no flush.
- Misaligned, saturation and wrap: sel=00, target=0x102 -> fault=1, HALT, imem_req=0, count unchanged, exit only on reset. CNT_W=2 with 5 redirects -> count=3. PC 0xFFFF_FFFC advances to 0x0.
